rst_seq_ctrl: RTL and testbench

- Reset request sequencer that sits upstream of the clock/reset generator.
- Merges power-on, software and watchdog reset requests with PLL lock status.
- Produces the generator's external active-low reset (sys_rst_n_o) with guaranteed minimum assertion width, then waits for PLL lock, with timeout and bounded retry.
- Reports ready status, sticky reset cause and fault flags to the system control registers.

---
 rtl/rst_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Reset request sequencer: merges POR/SW/WDT requests with PLL lock status and
// drives the clock/reset generator's external reset with bounded lock retries.
module rst_seq_ctrl #(
  parameter int unsigned ASSERT_CYCLES = 16,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT  = 1024,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_rst_req,
  input  logic       wdt_rst_req,
  input  logic       pll_locked,
  input  logic       cause_clr,
  output logic       sys_rst_n_o,
  output logic       sys_ready,
  output logic [3:0] rst_cause,
  output logic       lock_err,
  output logic       fault,
  output logic [1:0] retry_cnt
);

  localparam int unsigned ACNT_W = $clog2(ASSERT_CYCLES + 1);
  localparam int unsigned SCNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TCNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [ACNT_W-1:0] ACNT_RELOAD = ACNT_W'(ASSERT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } state_e;

  state_e            state_q, state_nxt;
  logic [ACNT_W-1:0] acnt_q, acnt_nxt;
  logic [SCNT_W-1:0] scnt_q, scnt_nxt, scnt_inc;
  logic [TCNT_W-1:0] tcnt_q, tcnt_nxt, tcnt_inc;
  logic [1:0]        retry_nxt;
  logic [3:0]        cause_set, cause_nxt;
  logic              lock_err_nxt;
  logic              req;
  logic              lk_meta, lk_s;

  assign req      = sw_rst_req | wdt_rst_req;
  assign scnt_inc = scnt_q + SCNT_W'(1);
  assign tcnt_inc = tcnt_q + TCNT_W'(1);

  // Lock synchronizer; lock is ignored while the generator is held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= pll_locked & sys_rst_n_o;
      lk_s    <= lk_meta;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    acnt_nxt     = ACNT_RELOAD;
    scnt_nxt     = '0;
    tcnt_nxt     = '0;
    retry_nxt    = retry_cnt;
    cause_set    = 4'b0000;
    lock_err_nxt = lock_err;

    unique case (state_q)
      ST_ASSERT: begin
        if (req) begin
          retry_nxt = 2'd0;
          cause_set = {1'b0, wdt_rst_req, sw_rst_req, 1'b0};
        end else if (acnt_q == '0) begin
          state_nxt = ST_WAIT_LOCK;
        end else begin
          acnt_nxt = acnt_q - ACNT_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        if (req) begin
          state_nxt = ST_ASSERT;
          retry_nxt = 2'd0;
          cause_set = {1'b0, wdt_rst_req, sw_rst_req, 1'b0};
        end else if (lk_s && (scnt_inc == SCNT_W'(STABLE_CYCLES))) begin
          // Stable lock wins over a timeout landing on the same cycle.
          state_nxt = ST_RUN;
          retry_nxt = 2'd0;
        end else if (tcnt_inc == TCNT_W'(LOCK_TIMEOUT)) begin
          lock_err_nxt = 1'b1;
          retry_nxt    = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;
          state_nxt    = (32'(retry_nxt) == MAX_RETRY) ? ST_FAULT : ST_ASSERT;
        end else begin
          tcnt_nxt = tcnt_inc;
          scnt_nxt = lk_s ? scnt_inc : '0;
        end
      end

      ST_RUN: begin
        cause_set = {~lk_s, wdt_rst_req, sw_rst_req, 1'b0};
        if (cause_set != 4'b0000) begin
          state_nxt = ST_ASSERT;
        end
      end

      ST_FAULT: begin
        state_nxt = ST_FAULT;
      end

      default: begin
        state_nxt = ST_ASSERT;
      end
    endcase

    cause_nxt = (cause_clr ? 4'b0000 : rst_cause) | cause_set;
  end

  // State, counters and registered outputs; outputs decode the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ASSERT;
      acnt_q      <= ACNT_RELOAD;
      scnt_q      <= '0;
      tcnt_q      <= '0;
      sys_rst_n_o <= 1'b0;
      sys_ready   <= 1'b0;
      fault       <= 1'b0;
      rst_cause   <= 4'b0001;
      lock_err    <= 1'b0;
      retry_cnt   <= 2'd0;
    end else begin
      state_q     <= state_nxt;
      acnt_q      <= acnt_nxt;
      scnt_q      <= scnt_nxt;
      tcnt_q      <= tcnt_nxt;
      sys_rst_n_o <= (state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_RUN);
      sys_ready   <= (state_nxt == ST_RUN);
      fault       <= (state_nxt == ST_FAULT);
      rst_cause   <= cause_nxt;
      lock_err    <= lock_err_nxt;
      retry_cnt   <= retry_nxt;
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed vector table, hand-built corner sequences and
// random traffic checked every cycle against a timeline-based reference model.
module tb_rst_seq_ctrl;

  localparam int AC = 16;
  localparam int SC = 8;
  localparam int LT = 1024;
  localparam int MR = 3;

  logic       clk;
  logic       rst_n;
  logic       sw_rst_req;
  logic       wdt_rst_req;
  logic       pll_locked;
  logic       cause_clr;
  logic       sys_rst_n_o;
  logic       sys_ready;
  logic [3:0] rst_cause;
  logic       lock_err;
  logic       fault;
  logic [1:0] retry_cnt;

  rst_seq_ctrl #(
    .ASSERT_CYCLES(AC),
    .STABLE_CYCLES(SC),
    .LOCK_TIMEOUT (LT),
    .MAX_RETRY    (MR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_rst_req (sw_rst_req),
    .wdt_rst_req(wdt_rst_req),
    .pll_locked (pll_locked),
    .cause_clr  (cause_clr),
    .sys_rst_n_o(sys_rst_n_o),
    .sys_ready  (sys_ready),
    .rst_cause  (rst_cause),
    .lock_err   (lock_err),
    .fault      (fault),
    .retry_cnt  (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  logic rnd_pll;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference model: phases with absolute deadlines, lock seen through a delay queue.
  localparam int M_HOLD = 0;
  localparam int M_LOCK = 1;
  localparam int M_RUN  = 2;
  localparam int M_DEAD = 3;

  int       m_mode;
  int       m_release_at;
  int       m_wl_start;
  int       m_run_len;
  int       m_timeouts;
  bit       m_lock_err;
  bit [3:0] m_cause;
  bit       m_gate_q[$];

  function automatic bit m_rst_o();
    return (m_mode == M_LOCK) || (m_mode == M_RUN);
  endfunction

  task automatic model_reset();
    m_mode       = M_HOLD;
    m_release_at = AC;
    m_wl_start   = 0;
    m_run_len    = 0;
    m_timeouts   = 0;
    m_lock_err   = 1'b0;
    m_cause      = 4'b0001;
    m_gate_q.delete();
  endtask

  task automatic enter_hold();
    m_mode       = M_HOLD;
    m_release_at = edge_n + AC;
  endtask

  task automatic model_tick(input bit s, input bit w, input bit p, input bit c);
    bit       lk;
    bit [3:0] set;
    int       run;
    lk = (m_gate_q.size() >= 2) ? m_gate_q[m_gate_q.size() - 2] : 1'b0;
    m_gate_q.push_back(p & m_rst_o());
    if (m_gate_q.size() > 4) void'(m_gate_q.pop_front());
    set = 4'b0000;
    case (m_mode)
      M_HOLD: begin
        if (s || w) begin
          set = {1'b0, w, s, 1'b0};
          m_timeouts = 0;
          enter_hold();
        end else if (edge_n == m_release_at) begin
          m_mode     = M_LOCK;
          m_wl_start = edge_n;
          m_run_len  = 0;
        end
      end
      M_LOCK: begin
        if (s || w) begin
          set = {1'b0, w, s, 1'b0};
          m_timeouts = 0;
          enter_hold();
        end else begin
          run = lk ? m_run_len + 1 : 0;
          if (run == SC) begin
            m_mode     = M_RUN;
            m_timeouts = 0;
          end else if (edge_n - m_wl_start == LT) begin
            m_lock_err = 1'b1;
            if (m_timeouts < 3) m_timeouts++;
            if (m_timeouts == MR) m_mode = M_DEAD;
            else enter_hold();
          end else begin
            m_run_len = run;
          end
        end
      end
      M_RUN: begin
        set = {~lk, w, s, 1'b0};
        if (set != 4'b0000) enter_hold();
      end
      default: ;
    endcase
    m_cause = (c ? 4'b0000 : m_cause) | set;
  endtask

  task automatic check_model();
    chk("model sys_rst_n_o", int'(sys_rst_n_o), int'(m_rst_o()));
    chk("model sys_ready",   int'(sys_ready),   int'(m_mode == M_RUN));
    chk("model fault",       int'(fault),       int'(m_mode == M_DEAD));
    chk("model rst_cause",   int'(rst_cause),   int'(m_cause));
    chk("model lock_err",    int'(lock_err),    int'(m_lock_err));
    chk("model retry_cnt",   int'(retry_cnt),   m_timeouts);
  endtask

  task automatic step(input logic s, input logic w, input logic p, input logic c);
    sw_rst_req  = s;
    wdt_rst_req = w;
    pll_locked  = p;
    cause_clr   = c;
    @(posedge clk);
    edge_n++;
    model_tick(s, w, p, c);
    #1;
    check_model();
  endtask

  // Asserts rst_n off-edge, checks the asynchronous reset values, releases on negedge.
  task automatic apply_reset();
    rst_n       = 1'b0;
    sw_rst_req  = 1'b0;
    wdt_rst_req = 1'b0;
    cause_clr   = 1'b0;
    #1;
    chk("reset sys_rst_n_o", int'(sys_rst_n_o), 0);
    chk("reset sys_ready",   int'(sys_ready),   0);
    chk("reset rst_cause",   int'(rst_cause),   1);
    chk("reset lock_err",    int'(lock_err),    0);
    chk("reset fault",       int'(fault),       0);
    chk("reset retry_cnt",   int'(retry_cnt),   0);
    model_reset();
    edge_n = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       sw;
    logic       wdt;
    logic       pll;
    logic       clr;
    int         n;
    logic       e_rst;
    logic       e_rdy;
    logic [3:0] e_cause;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic s, input logic w, input logic p, input logic c,
                               input int n, input logic er, input logic ey, input logic [3:0] ec);
    vec_t v;
    v.sw = s; v.wdt = w; v.pll = p; v.clr = c; v.n = n;
    v.e_rst = er; v.e_rdy = ey; v.e_cause = ec;
    return v;
  endfunction

  initial begin
    rst_n       = 1'b1;
    sw_rst_req  = 1'b0;
    wdt_rst_req = 1'b0;
    pll_locked  = 1'b1;
    cause_clr   = 1'b0;

    //               sw wdt pll clr  n  rst rdy cause
    vecs.push_back(mkv(0, 0, 1, 0, 15, 0, 0, 4'b0001));
    vecs.push_back(mkv(0, 0, 1, 0,  1, 1, 0, 4'b0001));
    vecs.push_back(mkv(0, 0, 1, 0,  9, 1, 0, 4'b0001));
    vecs.push_back(mkv(0, 0, 1, 0,  1, 1, 1, 4'b0001));
    vecs.push_back(mkv(0, 0, 1, 0,  3, 1, 1, 4'b0001));
    vecs.push_back(mkv(1, 0, 1, 0,  1, 0, 0, 4'b0011));
    vecs.push_back(mkv(0, 0, 1, 0, 15, 0, 0, 4'b0011));
    vecs.push_back(mkv(0, 0, 1, 0,  1, 1, 0, 4'b0011));
    vecs.push_back(mkv(0, 0, 1, 0,  9, 1, 0, 4'b0011));
    vecs.push_back(mkv(0, 0, 1, 0,  1, 1, 1, 4'b0011));
    vecs.push_back(mkv(0, 0, 0, 0,  1, 1, 1, 4'b0011));
    vecs.push_back(mkv(0, 0, 0, 0,  1, 1, 1, 4'b0011));
    vecs.push_back(mkv(0, 1, 0, 1,  1, 0, 0, 4'b1100));
    vecs.push_back(mkv(0, 0, 1, 0, 10, 0, 0, 4'b1100));
    vecs.push_back(mkv(1, 0, 1, 0,  1, 0, 0, 4'b1110));
    vecs.push_back(mkv(0, 0, 1, 0, 15, 0, 0, 4'b1110));
    vecs.push_back(mkv(0, 0, 1, 0,  1, 1, 0, 4'b1110));
    vecs.push_back(mkv(0, 0, 1, 0,  9, 1, 0, 4'b1110));
    vecs.push_back(mkv(0, 0, 1, 0,  1, 1, 1, 4'b1110));
    vecs.push_back(mkv(0, 0, 1, 1,  1, 1, 1, 4'b0000));
    vecs.push_back(mkv(1, 0, 1, 1,  1, 0, 0, 4'b0010));

    #2;
    apply_reset();
    foreach (vecs[i]) begin
      repeat (vecs[i].n) step(vecs[i].sw, vecs[i].wdt, vecs[i].pll, vecs[i].clr);
      chk($sformatf("vec%0d sys_rst_n_o", i), int'(sys_rst_n_o), int'(vecs[i].e_rst));
      chk($sformatf("vec%0d sys_ready", i),   int'(sys_ready),   int'(vecs[i].e_rdy));
      chk($sformatf("vec%0d rst_cause", i),   int'(rst_cause),   int'(vecs[i].e_cause));
      chk($sformatf("vec%0d fault", i),       int'(fault),       0);
    end

    // Lock glitch in WAIT_LOCK: 5 high, 3 low, then steady high.
    pll_locked = 1'b0;
    apply_reset();
    for (int n = 1; n <= 45; n++) begin
      step(0, 0, (n >= 20 && n <= 24) || n >= 28, 0);
      if (n == 16) chk("glitch release", int'(sys_rst_n_o), 1);
      if (n >= 17) chk("glitch sys_ready", int'(sys_ready), int'(n >= 37));
    end

    // Lock never arrives: three timeouts then FAULT, requests ignored.
    pll_locked = 1'b0;
    apply_reset();
    for (int n = 1; n <= 3120; n++) begin
      step(0, 0, 0, 0);
      if (n == 1039) chk("timeout lock_err early", int'(lock_err), 0);
      if (n == 1040) begin
        chk("timeout1 lock_err",    int'(lock_err),    1);
        chk("timeout1 retry_cnt",   int'(retry_cnt),   1);
        chk("timeout1 sys_rst_n_o", int'(sys_rst_n_o), 0);
      end
      if (n == 1055) chk("retry assert low",  int'(sys_rst_n_o), 0);
      if (n == 1056) chk("retry assert rise", int'(sys_rst_n_o), 1);
      if (n == 2080) chk("timeout2 retry_cnt", int'(retry_cnt), 2);
      if (n == 3119) chk("fault early", int'(fault), 0);
    end
    chk("fault set",         int'(fault),       1);
    chk("fault sys_rst_n_o", int'(sys_rst_n_o), 0);
    chk("fault retry_cnt",   int'(retry_cnt),   3);
    chk("fault sys_ready",   int'(sys_ready),   0);
    step(1, 0, 1, 0);
    step(0, 1, 1, 0);
    repeat (20) step(0, 0, 1, 0);
    chk("fault sticky",      int'(fault),     1);
    chk("fault no cause",    int'(rst_cause), 1);
    apply_reset();

    // rst_n asserted in the middle of WAIT_LOCK.
    pll_locked = 1'b0;
    repeat (20) step(0, 0, 0, 0);
    chk("midwait sys_rst_n_o", int'(sys_rst_n_o), 1);
    apply_reset();

    // Random traffic, lock mostly present.
    rnd_pll = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) rnd_pll = ~rnd_pll;
      step($urandom_range(63) == 0, $urandom_range(127) == 0, rnd_pll, $urandom_range(49) == 0);
      if ($urandom_range(1999) == 0) apply_reset();
    end

    // Random traffic, lock mostly absent so timeouts and FAULT are reached.
    apply_reset();
    rnd_pll = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(699) == 0) rnd_pll = ~rnd_pll;
      step($urandom_range(1499) == 0, $urandom_range(1999) == 0, rnd_pll,
           $urandom_range(99) == 0);
      if ($urandom_range(2999) == 0) apply_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
